fb_scanout: RTL and testbench
=============================

# fb_scanout

Video scanout engine for the byte-wide read port of the framebuffer. Generates 640x480@60 raster timing, issues one framebuffer byte address per pixel clock, absorbs the framebuffer's one-cycle read latency, and emits aligned RGB332 pixels with sync and data-enable to the video encoder. It sits between the framebuffer read port (address out, byte in) and the display output stage, and exposes a vblank level so the CPU can update the framebuffer tear-free.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- FB_WIDTH, 128, framebuffer width in pixels (power of two)
- FB_HEIGHT, 64, framebuffer height in lines
- SCALE, 4, pixel and line replication factor
- WIN_X, 64, first screen column of the framebuffer window
- WIN_Y, 112, first screen line of the framebuffer window
- ADDR_WIDTH, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer byte address width (13)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- addr  out  ADDR_WIDTH  byte address to framebuffer read port
- data  in  8  byte returned by framebuffer, valid one clk after addr
- pixel  out  8  RGB332 pixel, 0 outside window and blanking
- de  out  1  data enable, high in active area
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- vblank  out  1  high during vertical blanking lines

## Operation

- Counters h (0..H_TOTAL-1, H_TOTAL=800) and v (0..V_TOTAL-1, V_TOTAL=525). h increments every clk; at h=H_TOTAL-1, h wraps to 0 and v increments; at v=V_TOTAL-1 with h wrap, v wraps to 0. (h=0,v=0) is the first active pixel.
- Active: h<H_ACTIVE and v<V_ACTIVE. hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752). vsync low for v in [490,492). vblank high for v>=V_ACTIVE.
- Window: h in [WIN_X, WIN_X+FB_WIDTH*SCALE) = [64,576) and v in [WIN_Y, WIN_Y+FB_HEIGHT*SCALE) = [112,368).
- fb_x=(h-WIN_X)/SCALE, fb_y=(v-WIN_Y)/SCALE; address = fb_y*FB_WIDTH+fb_x (concatenation, FB_WIDTH power of two). Implement with replication sub-counters, not dividers. Outside window addr is 0.
- pixel = data when the delayed in-window flag is set, else 0. No border colour.

## Timing

- Pipeline: stage 0 counters; stage 1 registered addr plus delayed flags; stage 2 framebuffer returns data; stage 3 registered pixel, de, hsync, vsync, vblank.
- Outputs for raster position (h,v) appear exactly 3 clk after counters hold (h,v); addr for (h,v) appears 1 clk after. All outputs share the same alignment.
- Reset (async assert, any time, including mid-line/mid-frame): h=v=0, all pipeline stages cleared; addr=0, pixel=0, de=0, hsync=1, vsync=1, vblank=0. After deassertion counting restarts at (0,0); first de=1 on the 3rd rising edge after release. Stale pipeline contents never reach outputs.
- Line period exactly 800 clk, frame exactly 420000 clk; no stalls, no handshake — data is sampled unconditionally one clk after addr.

## Test plan

- Reset: hold reset, toggle clk -> addr=0, pixel=0, de=0, hsync=1, vsync=1, vblank=0; release -> de rises on 3rd edge.
- Line timing: run one line -> de high 640 clk, then low 160; hsync low 96 clk starting 656 clk after de rise; period 800.
- Frame timing: run a full frame -> 480 lines with de, vsync low for lines 490-491, vblank high 45 lines, frame 420000 clk, wraps to line 0.
- Address sequence: line 112 -> addr 0 for h 64-67, 1 for 68-71, ..., 127 for 572-575; lines 113-115 repeat; line 116 starts at 128; last window pixel (575,367) -> 8191; addr 0 elsewhere.
- Data alignment: framebuffer model with 1-clk latency preloaded byte[a]=a[7:0]^a[12:5] -> every pixel with de high inside window matches model; pixel=0 in border and blanking.
- Mid-frame reset: assert reset at (300,200) for 2 clk -> outputs immediately at reset values, next frame starts from (0,0) with correct addresses, no stale pixel.

Source files
------------

// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 scanout engine for a byte-wide framebuffer.
//
// Generates raster timing, issues one framebuffer byte address per pixel
// clock for a SCALE-replicated FB_WIDTH x FB_HEIGHT window, absorbs the
// framebuffer's one-cycle read latency and emits aligned RGB332 pixels.
//
// Ports:
//   clk     in   pixel clock
//   reset   in   asynchronous, active-high reset
//   addr    out  byte address to framebuffer read port (0 outside window)
//   data    in   byte from framebuffer, valid one clk after addr
//   pixel   out  RGB332 pixel, 0 outside window and blanking
//   de      out  data enable, high in active area
//   hsync   out  horizontal sync, active-low
//   vsync   out  vertical sync, active-low
//   vblank  out  high during vertical blanking lines
//
// Pipeline: stage 0 counters, stage 1 addr + flags, stage 2 framebuffer
// read (flags delayed), stage 3 registered outputs. Every output for raster
// position (h,v) appears 3 clk after the counters hold (h,v); addr 1 clk after.
module fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_WIDTH   = 128,
  parameter int FB_HEIGHT  = 64,
  parameter int SCALE      = 4,
  parameter int WIN_X      = 64,
  parameter int WIN_Y      = 112,
  parameter int ADDR_WIDTH = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data,
  output logic [7:0]            pixel,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int FXW     = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  // fy takes the remaining address bits so {fy, fx} is exactly ADDR_WIDTH wide.
  localparam int FYW     = ADDR_WIDTH - FXW;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] WX_START = HW'(WIN_X);
  localparam logic [HW-1:0] WX_END   = HW'(WIN_X + FB_WIDTH*SCALE);
  localparam logic [VW-1:0] WY_START = VW'(WIN_Y);
  localparam logic [VW-1:0] WY_END   = VW'(WIN_Y + FB_HEIGHT*SCALE);
  localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);

  // stage 0: raster counters and replication sub-counters
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [SW-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic [FXW-1:0] fx_q, fx_d;
  logic [FYW-1:0] fy_q, fy_d;

  // stage 0 decode
  logic win_h_s, win_v_s, act_s, hs_s, vs_s, vb_s;
  logic [ADDR_WIDTH-1:0] addr_d;

  // stage 1 / stage 2 flag pipeline
  logic [ADDR_WIDTH-1:0] addr_q;
  logic win1_q, de1_q, hs1_q, vs1_q, vb1_q;
  logic win2_q, de2_q, hs2_q, vs2_q, vb2_q;

  // stage 3 outputs
  logic [7:0] pixel_q, pixel_d;
  logic de_q, hs_q, vs_q, vb_q;

  // Raster counter next-state: h wraps every line, v advances on h wrap.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + VW'(1);
      end
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // Position decode for the pixel the counters currently point at.
  always_comb begin
    win_h_s = (h_q >= WX_START) && (h_q < WX_END);
    win_v_s = (v_q >= WY_START) && (v_q < WY_END);
    act_s   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_s    = !((h_q >= HS_START) && (h_q < HS_END));
    vs_s    = !((v_q >= VS_START) && (v_q < VS_END));
    vb_s    = (v_q >= V_ACT);
  end

  // Horizontal replication: sx/fx hold the window-relative position of h_q.
  // They sit at zero outside the window, so they start clean at WIN_X; the
  // wrap of fx after the last window pixel is harmless because the next
  // column is outside the window and clears them anyway.
  always_comb begin
    sx_d = sx_q;
    fx_d = fx_q;
    if (win_h_s) begin
      if (sx_q == S_LAST) begin
        sx_d = '0;
        fx_d = fx_q + FXW'(1);
      end else begin
        sx_d = sx_q + SW'(1);
      end
    end else begin
      sx_d = '0;
      fx_d = '0;
    end
  end

  // Vertical replication: same scheme as horizontal, stepped once per line.
  always_comb begin
    sy_d = sy_q;
    fy_d = fy_q;
    if (h_q == H_LAST) begin
      if (win_v_s) begin
        if (sy_q == S_LAST) begin
          sy_d = '0;
          fy_d = fy_q + FYW'(1);
        end else begin
          sy_d = sy_q + SW'(1);
        end
      end else begin
        sy_d = '0;
        fy_d = '0;
      end
    end else begin
      sy_d = sy_q;
      fy_d = fy_q;
    end
  end

  // Framebuffer address: fy*FB_WIDTH + fx is a plain concatenation.
  always_comb begin
    if (win_h_s && win_v_s) begin
      addr_d = {fy_q, fx_q};
    end else begin
      addr_d = '0;
    end
  end

  // Stage 3 pixel select: data is only meaningful for in-window positions.
  always_comb begin
    if (win2_q) begin
      pixel_d = data;
    end else begin
      pixel_d = 8'h00;
    end
  end

  // Stage 0 state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      sx_q <= '0;
      fx_q <= '0;
      sy_q <= '0;
      fy_q <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      sx_q <= sx_d;
      fx_q <= fx_d;
      sy_q <= sy_d;
      fy_q <= fy_d;
    end
  end

  // Stages 1 and 2: address register and flag delay line (syncs idle high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      win1_q <= 1'b0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vb1_q  <= 1'b0;
      win2_q <= 1'b0;
      de2_q  <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      vb2_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      win1_q <= win_h_s && win_v_s;
      de1_q  <= act_s;
      hs1_q  <= hs_s;
      vs1_q  <= vs_s;
      vb1_q  <= vb_s;
      win2_q <= win1_q;
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      vb2_q  <= vb1_q;
    end
  end

  // Stage 3: registered video outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_q <= 8'h00;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      vb_q    <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      de_q    <= de2_q;
      hs_q    <= hs2_q;
      vs_q    <= vs2_q;
      vb_q    <= vb2_q;
    end
  end

  assign addr   = addr_q;
  assign pixel  = pixel_q;
  assign de     = de_q;
  assign hsync  = hs_q;
  assign vsync  = vs_q;
  assign vblank = vb_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout. Horizontal timing and the horizontal window use
// the standard 640-wide values; the vertical timing and framebuffer height
// are shortened so that a whole frame plus a mid-frame reset stays short.
// A scoreboard queue holds the expected outputs for each raster position,
// computed from division-based reference formulas, and pops them when the
// DUT's pipeline delivers that position.
module tb_fb_scanout;

  localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int FB_WIDTH = 128, FB_HEIGHT = 8, SCALE = 4;
  localparam int WIN_X = 64, WIN_Y = 4;
  localparam int AW = 10;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 46;
  localparam int FRAME = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [7:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
    logic       vb;
  } out_t;

  localparam out_t RST_OUT = '{pix: 8'h00, de: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic [7:0]    fb_data;
  logic [7:0]    pixel;
  logic          de, hsync, vsync, vblank;

  int n_checks = 0;
  int n_fail   = 0;

  // model raster position of the DUT counters at the current sample
  int mh, mv, s;
  bit phase1;
  logic de_prev, hs_prev;
  int de_cnt, hs_cnt, vs_cnt, vb_cnt, rise_n;
  int first_rise, second_rise, first_hs_fall;
  bit frame_rise;

  out_t          exp_q[$];
  logic [AW-1:0] aexp_q[$];

  fb_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .SCALE(SCALE),
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .data  (fb_data),
    .pixel (pixel),
    .de    (de),
    .hsync (hsync),
    .vsync (vsync),
    .vblank(vblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // framebuffer contents: non-zero at address 0 so blanking vs window is visible
  function automatic logic [7:0] fb_byte(input logic [AW-1:0] a);
    logic [AW-1:0] sh;
    sh = a >> 2;
    return a[7:0] ^ sh[7:0] ^ 8'h5A;
  endfunction

  // framebuffer read port with one clk latency
  always_ff @(posedge clk) fb_data <= fb_byte(addr);

  function automatic bit in_win(input int h, input int v);
    return (h >= WIN_X) && (h < WIN_X + FB_WIDTH*SCALE) &&
           (v >= WIN_Y) && (v < WIN_Y + FB_HEIGHT*SCALE);
  endfunction

  function automatic logic [AW-1:0] model_addr(input int h, input int v);
    int a;
    if (!in_win(h, v)) return '0;
    a = ((v - WIN_Y) / SCALE) * FB_WIDTH + (h - WIN_X) / SCALE;
    return AW'(a);
  endfunction

  function automatic out_t model_out(input int h, input int v);
    out_t o;
    o.de  = (h < H_ACTIVE) && (v < V_ACTIVE);
    o.hs  = !((h >= 656) && (h < 752));
    o.vs  = !((v >= 42) && (v < 44));
    o.vb  = (v >= V_ACTIVE);
    o.pix = in_win(h, v) ? fb_byte(model_addr(h, v)) : 8'h00;
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
    end
  endtask

  // restart the scoreboard after a reset release: pipeline drains reset values
  task automatic restart();
    exp_q.delete();
    aexp_q.delete();
    repeat (3) exp_q.push_back(RST_OUT);
    aexp_q.push_back('0);
    mh = 0;
    mv = 0;
    s  = 0;
    de_prev = 1'b0;
    hs_prev = 1'b1;
  endtask

  // one sample per cycle at negedge: push expectation, pop and compare
  task automatic sample();
    out_t e, obs;
    logic [AW-1:0] ea;
    exp_q.push_back(model_out(mh, mv));
    aexp_q.push_back(model_addr(mh, mv));
    e   = exp_q.pop_front();
    ea  = aexp_q.pop_front();
    obs = '{pix: pixel, de: de, hs: hsync, vs: vsync, vb: vblank};
    check_eq("outs", 32'(obs), 32'(e));
    check_eq("addr", 32'(addr), 32'(ea));
    if (phase1) begin
      if (s >= 3 && s < 3 + FRAME) begin
        de_cnt += int'(de);
        hs_cnt += int'(!hsync);
        vs_cnt += int'(!vsync);
        vb_cnt += int'(vblank);
        if (de && !de_prev) rise_n++;
      end
      if (de && !de_prev) begin
        if (first_rise < 0) first_rise = s;
        else if (second_rise < 0) second_rise = s;
        if (s == 3 + FRAME) frame_rise = 1'b1;
      end
      if (!hsync && hs_prev && first_hs_fall < 0) first_hs_fall = s;
    end
    de_prev = de;
    hs_prev = hsync;
    s++;
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  initial begin
    out_t obs;
    reset = 1'b1;
    mh = 0; mv = 0; s = 0;
    phase1 = 1'b0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vb_cnt = 0; rise_n = 0;
    first_rise = -1; second_rise = -1; first_hs_fall = -1;
    frame_rise = 1'b0;

    // reset held with clock running
    repeat (5) @(negedge clk);
    obs = '{pix: pixel, de: de, hs: hsync, vs: vsync, vb: vblank};
    check_eq("rst_outs", 32'(obs), 32'(RST_OUT));
    check_eq("rst_addr", 32'(addr), 32'd0);

    // release and run one full frame plus a little, checking every cycle
    reset = 1'b0;
    restart();
    phase1 = 1'b1;
    for (int i = 0; i < FRAME + 10; i++) begin
      sample();
      @(negedge clk);
    end
    phase1 = 1'b0;

    check_eq("de_first_edge", 32'(first_rise), 32'd3);
    check_eq("line_period", 32'(second_rise - first_rise), 32'd800);
    check_eq("hs_after_de", 32'(first_hs_fall - first_rise), 32'd656);
    check_eq("de_cycles", 32'(de_cnt), 32'(640 * V_ACTIVE));
    check_eq("de_lines", 32'(rise_n), 32'(V_ACTIVE));
    check_eq("hs_cycles", 32'(hs_cnt), 32'(96 * V_TOTAL));
    check_eq("vs_cycles", 32'(vs_cnt), 32'(2 * H_TOTAL));
    check_eq("vb_cycles", 32'(vb_cnt), 32'(6 * H_TOTAL));
    check_eq("frame_wrap", 32'(frame_rise), 32'd1);

    // advance to raster position (300,6), inside the window
    for (int i = 0; i < 6 * H_TOTAL + 300 - 10; i++) begin
      sample();
      @(negedge clk);
    end

    // asynchronous mid-frame reset, held for 2 clk
    #2 reset = 1'b1;
    #1;
    obs = '{pix: pixel, de: de, hs: hsync, vs: vsync, vb: vblank};
    check_eq("mid_rst_outs", 32'(obs), 32'(RST_OUT));
    check_eq("mid_rst_addr", 32'(addr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = '{pix: pixel, de: de, hs: hsync, vs: vsync, vb: vblank};
      check_eq("mid_rst_hold", 32'(obs), 32'(RST_OUT));
      check_eq("mid_rst_hold_addr", 32'(addr), 32'd0);
    end

    // restart from (0,0) and run past the whole window
    reset = 1'b0;
    restart();
    for (int i = 0; i < (WIN_Y + FB_HEIGHT*SCALE + 2) * H_TOTAL + 10; i++) begin
      sample();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
